// File: rtl/fb_rect_writer_if.sv
// Command handshake and frame-buffer write bus for fb_rect_writer.
// FB_RECT_OUTLINE_EN adds the outline command bit.
interface fb_rect_writer_if #(
    parameter int AW = 15,
    parameter int DW = 3,
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          start;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] w;
    logic [YW-1:0] h;
    logic [DW-1:0] color;
`ifdef FB_RECT_OUTLINE_EN
    logic          outline;
`endif
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite;

    modport master (
`ifdef FB_RECT_OUTLINE_EN
        output outline,
`endif
        output start, x0, y0, w, h, color,
        input  busy, done, addr_in, data_in, regwrite
    );

    modport slave (
`ifdef FB_RECT_OUTLINE_EN
        input  outline,
`endif
        input  start, x0, y0, w, h, color,
        output busy, done, addr_in, data_in, regwrite
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Clipped rectangle fill engine for the frame-buffer write port, one pixel per clock.
// Optional FB_RECT_OUTLINE_EN: draw only the unclipped rectangle's border.
module fb_rect_writer #(
    parameter int AW       = 15,
    parameter int DW       = 3,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7
) (
    input  logic            clk,
    input  logic            reset,
    fb_rect_writer_if.slave bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] FILL   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

    localparam logic [XW:0] SW = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH = (YW+1)'(SCREEN_H);

    logic [1:0]    state;
    logic [XW-1:0] x0_q, w_q, col, nxt_col;
    logic [YW-1:0] y0_q, h_q, row, nxt_row;
    logic [DW-1:0] color_q;
`ifdef FB_RECT_OUTLINE_EN
    logic          outline_q;
`endif
    logic [XW:0]   sum_x, xe_c, xe, span;
    logic [YW:0]   sum_y, ye_c, ye;
    logic [AW-1:0] addr, nxt_addr, row_step, start_addr;
    logic          empty, row_end, last, nxt_en;

    always_comb begin
        sum_x      = {1'b0, x0_q} + {1'b0, w_q};
        sum_y      = {1'b0, y0_q} + {1'b0, h_q};
        xe_c       = (sum_x > SW) ? SW : sum_x;
        ye_c       = (sum_y > SH) ? SH : sum_y;
        span       = xe_c - {1'b0, x0_q};
        start_addr = AW'(y0_q) * AW'(SCREEN_W) + AW'(x0_q);
        empty      = (w_q == '0) || (h_q == '0) || ({1'b0, x0_q} >= SW) || ({1'b0, y0_q} >= SH);
        row_end    = ({1'b0, col} == xe - 1'b1);
        last       = row_end && ({1'b0, row} == ye - 1'b1);

        // Address walks incrementally; the only multiply is the start address in SETUP.
        if (state == SETUP) begin
            nxt_col  = x0_q;
            nxt_row  = y0_q;
            nxt_addr = start_addr;
        end else if (row_end) begin
            nxt_col  = x0_q;
            nxt_row  = row + YW'(1);
            nxt_addr = addr + row_step;
        end else begin
            nxt_col  = col + XW'(1);
            nxt_row  = row;
            nxt_addr = addr + AW'(1);
        end

`ifdef FB_RECT_OUTLINE_EN
        nxt_en = !outline_q
              || (nxt_col == x0_q) || ({1'b0, nxt_col} == sum_x - 1'b1)
              || (nxt_row == y0_q) || ({1'b0, nxt_row} == sum_y - 1'b1);
`else
        nxt_en = 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.regwrite <= 1'b0;
            bus.addr_in  <= '0;
            bus.data_in  <= '0;
            x0_q         <= '0;
            y0_q         <= '0;
            w_q          <= '0;
            h_q          <= '0;
            color_q      <= '0;
`ifdef FB_RECT_OUTLINE_EN
            outline_q    <= 1'b0;
`endif
            xe           <= '0;
            ye           <= '0;
            row_step     <= '0;
            col          <= '0;
            row          <= '0;
            addr         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        x0_q      <= bus.x0;
                        y0_q      <= bus.y0;
                        w_q       <= bus.w;
                        h_q       <= bus.h;
                        color_q   <= bus.color;
`ifdef FB_RECT_OUTLINE_EN
                        outline_q <= bus.outline;
`endif
                        bus.busy  <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    xe       <= xe_c;
                    ye       <= ye_c;
                    row_step <= AW'(SCREEN_W + 1) - AW'(span);
                    if (empty) begin
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= FINISH;
                    end else begin
                        col          <= nxt_col;
                        row          <= nxt_row;
                        addr         <= nxt_addr;
                        bus.regwrite <= nxt_en;
                        if (nxt_en) begin
                            bus.addr_in <= nxt_addr;
                            bus.data_in <= color_q;
                        end
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (last) begin
                        bus.regwrite <= 1'b0;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= FINISH;
                    end else begin
                        col          <= nxt_col;
                        row          <= nxt_row;
                        addr         <= nxt_addr;
                        bus.regwrite <= nxt_en;
                        if (nxt_en) begin
                            bus.addr_in <= nxt_addr;
                            bus.data_in <= color_q;
                        end
                    end
                end
                default: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed and randomized checks of fb_rect_writer against a loop-based pixel model.
// Build with FB_RECT_OUTLINE_EN to also exercise outline mode.
module tb_fb_rect_writer;
    localparam int AW = 15;
    localparam int DW = 3;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int NPIX = 160 * 120;

    logic clk = 1'b0;
    logic reset = 1'b0;

    int errors = 0;
    int checks = 0;
    int ram [NPIX];
    int exp_ram [NPIX];
    bit bad_addr = 1'b0;

    fb_rect_writer_if #(.AW(AW), .DW(DW), .XW(XW), .YW(YW)) bus ();

    fb_rect_writer #(
        .AW(AW), .DW(DW), .SCREEN_W(160), .SCREEN_H(120), .XW(XW), .YW(YW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Frame-buffer write port model
    always @(posedge clk) begin
        if (bus.regwrite === 1'b1) begin
            if (int'(bus.addr_in) >= NPIX) bad_addr <= 1'b1;
            else ram[int'(bus.addr_in)] <= int'(bus.data_in);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Scan order of the clipped rectangle; -1 marks a slot with no write.
    function automatic void model(input int x0, input int y0, input int w, input int h,
                                  input bit outl, output int q[$]);
        q = {};
        for (int r = y0; r < y0 + h && r < 120; r++)
            for (int c = x0; c < x0 + w && c < 160; c++) begin
                bit edge_px = (c == x0) || (c == x0 + w - 1) || (r == y0) || (r == y0 + h - 1);
                q.push_back((outl && !edge_px) ? -1 : r * 160 + c);
            end
    endfunction

    task automatic run_rect(input int x0, input int y0, input int w, input int h, input int col,
                            input bit outl, input bit hold, input int exp_q[$], input string tag);
        int p = exp_q.size();
        @(negedge clk);
        bus.x0 = XW'(x0);
        bus.y0 = YW'(y0);
        bus.w = XW'(w);
        bus.h = YW'(h);
        bus.color = DW'(col);
`ifdef FB_RECT_OUTLINE_EN
        bus.outline = outl;
`endif
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        chk({tag, ".busy1"}, 32'(bus.busy), 1);
        chk({tag, ".we1"}, 32'(bus.regwrite), 0);
        for (int k = 0; k < p; k++) begin
            @(negedge clk);
            chk({tag, ".we"}, 32'(bus.regwrite), (exp_q[k] >= 0) ? 1 : 0);
            if (exp_q[k] >= 0) begin
                chk({tag, ".addr"}, 32'(bus.addr_in), exp_q[k]);
                chk({tag, ".data"}, 32'(bus.data_in), col);
                exp_ram[exp_q[k]] = col;
            end
            chk({tag, ".done_early"}, 32'(bus.done), 0);
            chk({tag, ".busy"}, 32'(bus.busy), 1);
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, ".done"}, 32'(bus.done), 1);
        chk({tag, ".busy_end"}, 32'(bus.busy), 0);
        chk({tag, ".we_end"}, 32'(bus.regwrite), 0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(bus.done), 0);
    endtask

    task automatic ram_check(input string tag);
        int bad = 0;
        for (int a = 0; a < NPIX; a++)
            if (ram[a] != exp_ram[a]) bad++;
        chk(tag, 32'(bad), 0);
    endtask

    initial begin
        int q[$];
        int x0, y0, w, h, col, nbusy, nwe, ndone;
        bit outl;

        for (int a = 0; a < NPIX; a++) exp_ram[a] = 0;
        bus.start = 1'b0;
        bus.x0 = '0;
        bus.y0 = '0;
        bus.w = '0;
        bus.h = '0;
        bus.color = '0;
`ifdef FB_RECT_OUTLINE_EN
        bus.outline = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 0);
        chk("rst.done", 32'(bus.done), 0);
        chk("rst.we", 32'(bus.regwrite), 0);
        chk("rst.addr", 32'(bus.addr_in), 0);
        chk("rst.data", 32'(bus.data_in), 0);

        q = '{810, 811, 812, 970, 971, 972};
        run_rect(10, 5, 3, 2, 5, 1'b0, 1'b0, q, "basic");
        @(negedge clk);
        ram_check("basic.ram");

        q = '{19038, 19039, 19198, 19199};
        run_rect(158, 118, 5, 5, 6, 1'b0, 1'b0, q, "clip");

        q = {};
        run_rect(40, 40, 0, 3, 2, 1'b0, 1'b0, q, "w0");
        run_rect(160, 10, 4, 4, 2, 1'b0, 1'b0, q, "x160");
        run_rect(10, 120, 4, 4, 2, 1'b0, 1'b0, q, "y120");

        model(30, 30, 4, 4, 1'b0, q);
        run_rect(30, 30, 4, 4, 3, 1'b0, 1'b1, q, "hold");
        nbusy = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy !== 1'b0) nbusy++;
        end
        chk("hold.no_requeue", 32'(nbusy), 0);

        for (int i = 0; i < 10; i++) begin
            x0 = $urandom_range(0, 170);
            y0 = $urandom_range(0, 125);
            w = $urandom_range(0, 20);
            h = $urandom_range(0, 12);
            col = $urandom_range(0, 7);
`ifdef FB_RECT_OUTLINE_EN
            outl = 1'($urandom_range(0, 1));
`else
            outl = 1'b0;
`endif
            model(x0, y0, w, h, outl, q);
            run_rect(x0, y0, w, h, col, outl, 1'b0, q, "rand");
        end

`ifdef FB_RECT_OUTLINE_EN
        q = '{0, 1, 2, 3, 160, -1, -1, 163, 320, 321, 322, 323};
        run_rect(0, 0, 4, 3, 7, 1'b1, 1'b0, q, "outline");
`endif

        @(negedge clk);
        ram_check("final.ram");
        chk("addr_range", 32'(bad_addr), 0);

        // Reset in the middle of a 4x4 fill
        @(negedge clk);
        bus.x0 = 8'd20;
        bus.y0 = 7'd20;
        bus.w = 8'd4;
        bus.h = 7'd4;
        bus.color = 3'd1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst.we_before", 32'(bus.regwrite), 1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.busy", 32'(bus.busy), 0);
        chk("midrst.done", 32'(bus.done), 0);
        chk("midrst.we", 32'(bus.regwrite), 0);
        chk("midrst.addr", 32'(bus.addr_in), 0);
        chk("midrst.data", 32'(bus.data_in), 0);
        @(negedge clk);
        reset = 1'b1;
        nwe = 0;
        ndone = 0;
        nbusy = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.regwrite !== 1'b0) nwe++;
            if (bus.done !== 1'b0) ndone++;
            if (bus.busy !== 1'b0) nbusy++;
        end
        chk("midrst.no_writes", 32'(nwe), 0);
        chk("midrst.no_done", 32'(ndone), 0);
        chk("midrst.idle", 32'(nbusy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
